serial_divider_v2: RTL and testbench

//  Parametrised Wishbone-slave restoring serial divider with XLEN width and signed/unsigned mode.

---
 rtl/serial_div_pkg.sv | 28 ++
 rtl/serial_div_core.sv | 111 +++++++++++
 rtl/serial_divider_v2.sv | 173 +++++++++++++++++
 tb/tb_serial_divider_v2.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_div_pkg.sv
// Shared definitions for the Wishbone serial divider: register offsets,
// CTRL bit positions and the divider FSM state type.
package serial_div_pkg;

    localparam logic [7:0] OFF_DIVIDEND  = 8'h00;
    localparam logic [7:0] OFF_DIVISOR   = 8'h04;
    localparam logic [7:0] OFF_CTRL      = 8'h08;
    localparam logic [7:0] OFF_QUOTIENT  = 8'h0C;
    localparam logic [7:0] OFF_REMAINDER = 8'h10;

    // CTRL write bits
    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_SIGNED   = 1;
    localparam int unsigned CTRL_IRQ_EN   = 3;
    localparam int unsigned CTRL_DONE_CLR = 4;
    // CTRL read bits
    localparam int unsigned CTRL_BUSY     = 0;
    localparam int unsigned CTRL_DONE     = 2;
    localparam int unsigned CTRL_DZ       = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ITER = 2'd2,
        ST_FIX  = 2'd3
    } div_state_e;

endpackage

// File: rtl/serial_div_core.sv
// Restoring shift-subtract divider: latches operands on start, optional
// sign handling around an XLEN-bit unsigned core, one quotient bit per cycle.
module serial_div_core
    import serial_div_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_signed,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_dz,
    output logic [XLEN-1:0] o_q,
    output logic [XLEN-1:0] o_r
);

    localparam int unsigned CW = $clog2(XLEN);

    div_state_e      r_state;
    div_state_e      w_state_n;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_rem;
    logic [CW-1:0]   r_cnt;
    logic            r_sgn;
    logic            r_sq;
    logic            r_sr;
    logic            r_dz;

    logic            w_bz;
    logic [XLEN:0]   w_sh;
    logic [XLEN+1:0] w_diff;
    logic            w_fit;

    assign w_bz   = (r_b == '0);
    assign w_sh   = {r_rem, r_a[XLEN-1]};
    assign w_diff = {1'b0, w_sh} - {2'b00, r_b};
    assign w_fit  = ~w_diff[XLEN+1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            ST_IDLE: if (i_start) w_state_n = ST_PREP;
            ST_PREP: w_state_n = w_bz ? ST_FIX : ST_ITER;
            ST_ITER: if (r_cnt == '0) w_state_n = ST_FIX;
            ST_FIX:  w_state_n = ST_IDLE;
        endcase
    end

    // r_a holds the dividend, then shifts into the quotient during ITER
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_sgn <= 1'b0;
            r_sq  <= 1'b0;
            r_sr  <= 1'b0;
            r_dz  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a   <= i_a;
                        r_b   <= i_b;
                        r_sgn <= i_signed;
                    end
                end
                ST_PREP: begin
                    r_rem <= '0;
                    r_cnt <= CW'(XLEN - 1);
                    r_dz  <= w_bz;
                    r_sq  <= 1'b0;
                    r_sr  <= 1'b0;
                    // a zero divisor keeps the raw dividend for the remainder
                    if (r_sgn && !w_bz) begin
                        if (r_a[XLEN-1]) r_a <= -r_a;
                        if (r_b[XLEN-1]) r_b <= -r_b;
                        r_sq <= r_a[XLEN-1] ^ r_b[XLEN-1];
                        r_sr <= r_a[XLEN-1];
                    end
                end
                ST_ITER: begin
                    r_cnt <= r_cnt - CW'(1);
                    r_a   <= {r_a[XLEN-2:0], w_fit};
                    r_rem <= w_fit ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_busy = (r_state != ST_IDLE);
        o_done = (r_state == ST_FIX);
        o_dz   = r_dz;
        o_q    = r_dz ? '1  : (r_sq ? -r_a : r_a);
        o_r    = r_dz ? r_a : (r_sr ? -r_rem : r_rem);
    end

endmodule

// File: rtl/serial_divider_v2.sv
// Wishbone slave wrapper around serial_div_core: decode, operand/result/status
// registers, LA export. Define DIV_IRQ_EN to add the irq_o completion interrupt.
module serial_divider_v2
    import serial_div_pkg::*;
#(
    parameter int unsigned    WBW       = 32,
    parameter int unsigned    XLEN      = 32,
    parameter logic [WBW-1:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [WBW/8-1:0]   wbs_sel_i,
    input  logic [WBW-1:0]     wbs_adr_i,
    input  logic [WBW-1:0]     wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [WBW-1:0]     wbs_dat_o,
    output logic [4*XLEN-1:0]  la_data_o
`ifdef DIV_IRQ_EN
    ,
    output logic               irq_o
`endif
);

    logic [XLEN-1:0] r_dvd;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic            r_signed;
    logic            r_done;
    logic            r_dz;
    logic            r_ack;
    logic [WBW-1:0]  r_dat;

    logic            w_valid;
    logic            w_acc;
    logic            w_wr;
    logic [7:0]      w_off;
    logic            w_ctrl_wr;
    logic            w_start;
    logic [WBW-1:0]  w_mask;
    logic [WBW-1:0]  w_rd;
    logic            w_done_n;
    logic            w_dz_n;

    logic            w_busy;
    logic            w_core_done;
    logic            w_core_dz;
    logic [XLEN-1:0] w_q;
    logic [XLEN-1:0] w_r;

`ifdef DIV_IRQ_EN
    logic            r_irq_en;
    logic            r_irq;
    logic            w_irq_en_n;
`endif

    // an access right after an ack is held off so acks never run back to back
    assign w_valid   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[WBW-1:8] == BASE_ADDR[WBW-1:8]);
    assign w_acc     = w_valid & ~r_ack;
    assign w_wr      = w_acc & wbs_we_i;
    assign w_off     = wbs_adr_i[7:0];
    assign w_ctrl_wr = w_wr && (w_off == OFF_CTRL);
    assign w_start   = w_ctrl_wr & wbs_dat_i[CTRL_START] & ~w_busy;

    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < WBW/8; i++) begin
            w_mask[8*i +: 8] = {8{wbs_sel_i[i]}};
        end
    end

    always_comb begin
        w_rd = '0;
        case (w_off)
            OFF_DIVIDEND:  w_rd[XLEN-1:0] = r_dvd;
            OFF_DIVISOR:   w_rd[XLEN-1:0] = r_dvs;
            OFF_QUOTIENT:  w_rd[XLEN-1:0] = r_quot;
            OFF_REMAINDER: w_rd[XLEN-1:0] = r_rem;
            OFF_CTRL: begin
                w_rd[CTRL_BUSY]   = w_busy;
                w_rd[CTRL_SIGNED] = r_signed;
                w_rd[CTRL_DONE]   = r_done;
                w_rd[CTRL_DZ]     = r_dz;
`ifdef DIV_IRQ_EN
                w_rd[CTRL_IRQ_EN] = r_irq_en;
`endif
            end
            default: ;
        endcase
    end

    // a completing operation overrides a DONE_CLR arriving in the same cycle
    always_comb begin
        w_done_n = r_done;
        w_dz_n   = r_dz;
`ifdef DIV_IRQ_EN
        w_irq_en_n = r_irq_en;
        if (w_ctrl_wr) w_irq_en_n = wbs_dat_i[CTRL_IRQ_EN];
`endif
        if (w_ctrl_wr && wbs_dat_i[CTRL_DONE_CLR]) w_done_n = 1'b0;
        if (w_start) begin
            w_done_n = 1'b0;
            w_dz_n   = 1'b0;
        end
        if (w_core_done) begin
            w_done_n = 1'b1;
            w_dz_n   = w_core_dz;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_signed <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_ack    <= 1'b0;
            r_dat    <= '0;
`ifdef DIV_IRQ_EN
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
`endif
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc && !wbs_we_i) ? w_rd : '0;
            if (w_wr && (w_off == OFF_DIVIDEND))
                r_dvd <= (r_dvd & ~w_mask[XLEN-1:0]) | (wbs_dat_i[XLEN-1:0] & w_mask[XLEN-1:0]);
            if (w_wr && (w_off == OFF_DIVISOR))
                r_dvs <= (r_dvs & ~w_mask[XLEN-1:0]) | (wbs_dat_i[XLEN-1:0] & w_mask[XLEN-1:0]);
            if (w_ctrl_wr) r_signed <= wbs_dat_i[CTRL_SIGNED];
            if (w_core_done) begin
                r_quot <= w_q;
                r_rem  <= w_r;
            end
            r_done <= w_done_n;
            r_dz   <= w_dz_n;
`ifdef DIV_IRQ_EN
            r_irq_en <= w_irq_en_n;
            r_irq    <= w_done_n & w_irq_en_n;
`endif
        end
    end

    serial_div_core #(
        .XLEN (XLEN)
    ) u_core (
        .i_clk    (clk_i),
        .i_rst    (reset_i),
        .i_start  (w_start),
        .i_signed (wbs_dat_i[CTRL_SIGNED]),
        .i_a      (r_dvd),
        .i_b      (r_dvs),
        .o_busy   (w_busy),
        .o_done   (w_core_done),
        .o_dz     (w_core_dz),
        .o_q      (w_q),
        .o_r      (w_r)
    );

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign la_data_o = {r_dvd, r_dvs, r_quot, r_rem};
`ifdef DIV_IRQ_EN
    assign irq_o = r_irq;
`endif

endmodule

// File: tb/tb_serial_divider_v2.sv
// Directed bench for serial_divider_v2 (default build; define DIV_IRQ_EN to
// also exercise irq_o).
module tb_serial_divider_v2;

    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam logic [31:0] A_DVD   = 32'h00;
    localparam logic [31:0] A_DVS   = 32'h04;
    localparam logic [31:0] A_CTRL  = 32'h08;
    localparam logic [31:0] A_QUOT  = 32'h0C;
    localparam logic [31:0] A_REM   = 32'h10;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         wbs_stb_i;
    logic         wbs_cyc_i;
    logic         wbs_we_i;
    logic [3:0]   wbs_sel_i;
    logic [31:0]  wbs_adr_i;
    logic [31:0]  wbs_dat_i;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic [127:0] la_data_o;
`ifdef DIV_IRQ_EN
    logic         irq_o;
`endif

    int checks = 0;
    int errors = 0;

    serial_divider_v2 #(
        .WBW       (32),
        .XLEN      (32),
        .BASE_ADDR (32'h3000_0000)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .la_data_o (la_data_o)
`ifdef DIV_IRQ_EN
        ,
        .irq_o     (irq_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Called just after an edge; returns one idle cycle after the ack.
    task automatic wb_xfer(input logic we, input logic [31:0] off, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd  = '0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = BASE + off;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk_i);
            #1;
            if (wbs_ack_o) begin
                got = 1'b1;
                rd  = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        chk("wb_ack", got, 1'b1);
        tick(1);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] dat);
        logic [31:0] dummy;
        wb_xfer(1'b1, off, dat, 4'hF, dummy);
    endtask

    task automatic rdr(input logic [31:0] off, output logic [31:0] v);
        wb_xfer(1'b0, off, 32'h0, 4'hF, v);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] v;
        logic        seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            rdr(A_CTRL, v);
            if (v[2]) seen = 1'b1;
        end
        chk({tag, "_done"}, seen, 1'b1);
    endtask

    initial begin
        logic [31:0] v;
        logic        saw;

        reset_i   = 1'b1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        tick(2);
        chk("rst_ack", wbs_ack_o, 1'b0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_la", la_data_o, 128'h0);
        reset_i = 1'b0;
        tick(1);
        rdr(A_CTRL, v);
        chk("rst_ctrl", v, 32'h0);

        // Unsigned 100/7 with exact latency from the START ack
        wr(A_DVD, 32'd100);
        wr(A_DVS, 32'd7);
        wr(A_CTRL, 32'h01);
        tick(32);
        chk("u_q_before34", la_data_o[63:32], 32'd0);
        tick(1);
        chk("u_q_at34", la_data_o[63:32], 32'd14);
        chk("u_r_at34", la_data_o[31:0], 32'd2);
        rdr(A_CTRL, v);
        chk("u_ctrl", v, 32'h04);
        rdr(A_QUOT, v);
        chk("u_quot", v, 32'd14);
        rdr(A_REM, v);
        chk("u_rem", v, 32'd2);
        chk("u_la_dvd", la_data_o[127:96], 32'd100);
        chk("u_la_dvs", la_data_o[95:64], 32'd7);

        // Signed -100/7 and 100/-7
        wr(A_DVD, 32'hFFFF_FF9C);
        wr(A_CTRL, 32'h03);
        wait_done("s1");
        rdr(A_QUOT, v);
        chk("s1_quot", v, 32'hFFFF_FFF2);
        rdr(A_REM, v);
        chk("s1_rem", v, 32'hFFFF_FFFE);
        rdr(A_CTRL, v);
        chk("s1_ctrl", v, 32'h06);
        wr(A_DVD, 32'd100);
        wr(A_DVS, 32'hFFFF_FFF9);
        wr(A_CTRL, 32'h03);
        wait_done("s2");
        rdr(A_QUOT, v);
        chk("s2_quot", v, 32'hFFFF_FFF2);
        rdr(A_REM, v);
        chk("s2_rem", v, 32'd2);

        // Divide by zero: 2-cycle latency
        wr(A_DVD, 32'd5);
        wr(A_DVS, 32'd0);
        wr(A_CTRL, 32'h01);
        chk("dz_q_before", la_data_o[63:32], 32'hFFFF_FFF2);
        tick(1);
        chk("dz_q_at2", la_data_o[63:32], 32'hFFFF_FFFF);
        chk("dz_r_at2", la_data_o[31:0], 32'd5);
        rdr(A_CTRL, v);
        chk("dz_ctrl", v, 32'h24);

        // Signed MIN / -1
        wr(A_DVD, 32'h8000_0000);
        wr(A_DVS, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h03);
        wait_done("min");
        rdr(A_QUOT, v);
        chk("min_quot", v, 32'h8000_0000);
        rdr(A_REM, v);
        chk("min_rem", v, 32'h0);
        rdr(A_CTRL, v);
        chk("min_ctrl", v, 32'h06);

        // Re-START and operand rewrite while busy
        wr(A_DVD, 32'd1000);
        wr(A_DVS, 32'd9);
        wr(A_CTRL, 32'h01);
        tick(3);
        wr(A_DVD, 32'h0000_1234);
        wr(A_CTRL, 32'h03);
        wait_done("busy");
        rdr(A_QUOT, v);
        chk("busy_quot", v, 32'd111);
        rdr(A_REM, v);
        chk("busy_rem", v, 32'd1);
        rdr(A_DVD, v);
        chk("busy_dvd_rb", v, 32'h0000_1234);
        rdr(A_CTRL, v);
        chk("busy_ctrl", v, 32'h06);

        // Byte select, unmapped offset, out-of-window access
        wb_xfer(1'b1, A_DVD, 32'hAAAA_AAFF, 4'b0001, v);
        rdr(A_DVD, v);
        chk("sel_dvd", v, 32'h0000_12FF);
        wr(32'h14, 32'hDEAD_BEEF);
        rdr(32'h14, v);
        chk("unmapped_rd", v, 32'h0);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_adr_i = BASE + 32'h100;
        saw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            if (wbs_ack_o) saw = 1'b1;
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        chk("oow_noack", saw, 1'b0);
        tick(1);

        // Reset mid-operation
        wr(A_DVD, 32'd50000);
        wr(A_DVS, 32'd3);
        wr(A_CTRL, 32'h01);
        tick(9);
        reset_i = 1'b1;
        tick(1);
        chk("mid_rst_ack", wbs_ack_o, 1'b0);
        chk("mid_rst_la", la_data_o, 128'h0);
        reset_i = 1'b0;
        tick(1);
        rdr(A_CTRL, v);
        chk("mid_rst_ctrl", v, 32'h0);
        rdr(A_QUOT, v);
        chk("mid_rst_quot", v, 32'h0);
        wr(A_DVD, 32'd9);
        wr(A_DVS, 32'd3);
        wr(A_CTRL, 32'h01);
        wait_done("post_rst");
        rdr(A_QUOT, v);
        chk("post_rst_quot", v, 32'd3);
        rdr(A_REM, v);
        chk("post_rst_rem", v, 32'd0);

`ifdef DIV_IRQ_EN
        wr(A_DVD, 32'd20);
        wr(A_DVS, 32'd6);
        wr(A_CTRL, 32'h09);
        chk("irq_low_busy", irq_o, 1'b0);
        wait_done("irq");
        chk("irq_high", irq_o, 1'b1);
        chk("irq_quot", la_data_o[63:32], 32'd3);
        wr(A_CTRL, 32'h18);
        chk("irq_clr", irq_o, 1'b0);
        rdr(A_CTRL, v);
        chk("irq_ctrl", v, 32'h08);
        wr(A_CTRL, 32'h01);
        wait_done("irq_off");
        chk("irq_disabled", irq_o, 1'b0);
`else
        wr(A_CTRL, 32'h18);
        rdr(A_CTRL, v);
        chk("ctrl_irqen_ignored", v, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
